// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
// Latency: none (wires only).
// Backpressure: byte_ready from the loader throttles the byte source; the memory port has none.
//
// Signals:
//   byte_valid / byte_data / byte_ready : valid/ready byte stream, source -> loader
//   mem_we / mem_addr / mem_wdata       : instruction memory write port, loader -> memory
//
// The master modport is the loader side, the slave modport is the source/memory side.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: packs bytes big-endian into words and writes them from index 0.
// Latency: 4 accepted bytes + 1 write cycle per word; all outputs registered.
// Backpressure: byte_ready is high only while collecting bytes; it drops during the write cycle.
//
// Ports:
//   clk, rst (async, active low)
//   start, num_words      : begin a load of num_words words (accepted in IDLE/DONE only)
//   bus (master modport)  : byte stream in, memory write port out
//   cpu_hold              : processor reset, high until the image is complete (and valid)
//   busy, done, err       : load status; err is the checksum mismatch flag
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum byte
// (8-bit sum of all data bytes). Without it err is tied low and there is no CHECK state.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ADDR_W:0] num_words,
    imem_loader_if.master   bus,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

    // Where the FSM goes once the last word has been written (or for an empty image).
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LAST = CHECK;
`else
    localparam state_t AFTER_LAST = DONE;
`endif

    state_t            state;
    state_t            nextState;
    logic [ADDR_W:0]   numWordsLat;
    logic [ADDR_W-1:0] wordIdx;
    logic [1:0]        byteCnt;
    logic [23:0]       wordBuf;     // first three bytes of the word being assembled
    logic              byteReady;
    logic              memWe;
    logic [31:0]       memAddr;
    logic [31:0]       memWdata;

    logic              byteReadyD;
    logic              memWeD;
    logic              busyD;
    logic              doneD;
    logic              cpuHoldD;
    logic              errD;

    logic              startAcc;
    logic              byteFire;
    logic              lastWord;

    assign startAcc = start && (state == IDLE || state == DONE);
    // byteReady is registered from the next state, so it is high exactly in RECV/CHECK.
    assign byteFire = bus.byte_valid && byteReady;
    // Compared one bit wider so a full 2^ADDR_W image ends at index 2^ADDR_W-1.
    assign lastWord = ({1'b0, wordIdx} == (numWordsLat - (ADDR_W + 1)'(1)));

    assign bus.byte_ready = byteReady;
    assign bus.mem_we     = memWe;
    assign bus.mem_addr   = memAddr;
    assign bus.mem_wdata  = memWdata;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       errQ;

    always_comb begin
        errD = errQ;
        if (startAcc) begin
            errD = 1'b0;
        end else if (state == CHECK && byteFire && bus.byte_data != sum) begin
            errD = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum  <= '0;
            errQ <= 1'b0;
        end else begin
            errQ <= errD;
            if (startAcc) begin
                sum <= '0;
            end else if (state == RECV && byteFire) begin
                sum <= sum + bus.byte_data;
            end
        end
    end

    assign err = errQ;
`else
    assign errD = 1'b0;
    assign err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    nextState = (num_words == '0) ? AFTER_LAST : RECV;
                end
            end
            RECV: begin
                if (byteFire && byteCnt == 2'd3) begin
                    nextState = WRITE;
                end
            end
            WRITE: begin
                nextState = lastWord ? AFTER_LAST : RECV;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (byteFire) begin
                    nextState = DONE;
                end
            end
`endif
            default: nextState = IDLE;
        endcase
    end

    // Output decode from the next state so every status output is a flop.
    always_comb begin
        byteReadyD = 1'b0;
        memWeD     = 1'b0;
        busyD      = 1'b0;
        doneD      = 1'b0;
        cpuHoldD   = 1'b1;
        case (nextState)
            RECV: begin
                byteReadyD = 1'b1;
                busyD      = 1'b1;
            end
            WRITE: begin
                memWeD = 1'b1;
                busyD  = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                byteReadyD = 1'b1;
                busyD      = 1'b1;
            end
`endif
            DONE: begin
                doneD    = 1'b1;
                cpuHoldD = errD;    // a bad image keeps the processor held
            end
            default: ;
        endcase
    end

    // Output registers and datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byteReady   <= 1'b0;
            memWe       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cpu_hold    <= 1'b1;
            memAddr     <= '0;
            memWdata    <= '0;
            numWordsLat <= '0;
            wordIdx     <= '0;
            byteCnt     <= '0;
            wordBuf     <= '0;
        end else begin
            byteReady <= byteReadyD;
            memWe     <= memWeD;
            busy      <= busyD;
            done      <= doneD;
            cpu_hold  <= cpuHoldD;

            if (startAcc) begin
                numWordsLat <= num_words;
                wordIdx     <= '0;
                byteCnt     <= '0;
            end

            if (state == RECV && byteFire) begin
                byteCnt <= byteCnt + 2'd1;
                wordBuf <= {wordBuf[15:0], bus.byte_data};
                // The write port only changes when the word is complete, so it holds
                // its last value everywhere outside WRITE.
                if (byteCnt == 2'd3) begin
                    memWdata <= {wordBuf, bus.byte_data};
                    memAddr  <= 32'(wordIdx);
                end
            end

            // Wraps to 0 after a full-size image; that value is never written.
            if (state == WRITE) begin
                wordIdx <= wordIdx + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int ADDR_W = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start = 1'b0;
    logic [ADDR_W:0] numWords = '0;
    logic            cpuHold, busy, done, err;

    imem_loader_if bus();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_words (numWords),
        .bus       (bus),
        .cpu_hold  (cpuHold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  stimQ[$];
    logic [63:0] gotQ[$];   // {addr, data} of every observed write
    logic [31:0] lastAddr, lastData;
    bit          prevWe;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkResetState(input string pfx);
        chk({pfx, "_ready"}, bus.byte_ready, 0);
        chk({pfx, "_we"},    bus.mem_we,     0);
        chk({pfx, "_addr"},  bus.mem_addr,   0);
        chk({pfx, "_wdata"}, bus.mem_wdata,  0);
        chk({pfx, "_busy"},  busy,           0);
        chk({pfx, "_done"},  done,           0);
        chk({pfx, "_err"},   err,            0);
        chk({pfx, "_hold"},  cpuHold,        1);
    endtask

    // Write monitor: collects writes and checks the write port is stable between writes.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            lastAddr = '0;
            lastData = '0;
            prevWe   = 1'b0;
        end else if (bus.mem_we) begin
            chk("we_ready", bus.byte_ready, 0);
            chk("we_pulse", prevWe, 0);
            gotQ.push_back({bus.mem_addr, bus.mem_wdata});
            lastAddr = bus.mem_addr;
            lastData = bus.mem_wdata;
            prevWe   = 1'b1;
        end else begin
            chk("hold_addr", bus.mem_addr, lastAddr);
            chk("hold_data", bus.mem_wdata, lastData);
            prevWe = 1'b0;
        end
    end

    task automatic randStim(input int n);
        stimQ.delete();
        for (int i = 0; i < 4 * n; i++) stimQ.push_back(8'($urandom));
    endtask

    // mode: 0 = valid held high, 1 = valid every other cycle, 2 = random valid.
    // abortAt >= 0 returns once that many bytes are accepted, with no final checks.
    task automatic runLoad(input int n, input int mode, input bit midStart,
                           input bit badSum, input int abortAt);
        int         total, k, c, doneAt, budget;
        bit         v, fire, expBusy1, expErr;
        logic [7:0] sum;
        logic [31:0] w;

        sum = '0;
        for (int j = 0; j < 4 * n; j++) sum = sum + stimQ[j];
        if (CK) stimQ.push_back(sum ^ {7'd0, badSum});
        total    = 4 * n + int'(CK);
        budget   = 12 * total + 40;
        expErr   = CK && badSum;
        expBusy1 = !(n == 0 && !CK);

        gotQ.delete();
        @(posedge clk); #1;
        start    = 1'b1;
        numWords = (ADDR_W + 1)'(n);
        @(posedge clk); #1;
        start  = 1'b0;
        c      = 1;
        k      = 0;
        doneAt = -1;
        chk("busy_c1", busy, expBusy1);
        chk("hold_c1", cpuHold, expBusy1);

        while (c < budget) begin
            if (abortAt >= 0 && k >= abortAt) begin
                bus.byte_valid = 1'b0;
                return;
            end
            if (done) begin
                doneAt = c;
                break;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = c[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (k >= total) v = 1'b0;
            bus.byte_valid = v;
            if (v) bus.byte_data = stimQ[k];
            else   bus.byte_data = 8'($urandom);
            fire = v && bus.byte_ready;
            if (midStart && k < total && $urandom_range(0, 5) == 0) begin
                start    = 1'b1;
                numWords = (ADDR_W + 1)'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            c++;
            if (fire) k++;
        end
        bus.byte_valid = 1'b0;
        start = 1'b0;

        chk("done_seen", doneAt >= 0, 1);
        if (mode == 0) chk("done_latency", doneAt, 5 * n + 1 + int'(CK));
        chk("consumed", k, total);
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("err", err, expErr);
        chk("hold_end", cpuHold, expErr);
        chk("nwrites", gotQ.size(), n);
        for (int i = 0; i < n && i < gotQ.size(); i++) begin
            w = (32'(stimQ[4*i]) << 24) | (32'(stimQ[4*i+1]) << 16)
              | (32'(stimQ[4*i+2]) << 8) | 32'(stimQ[4*i+3]);
            chk("write", gotQ[i], {32'(i), w});
        end
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2 checkResetState("rst0");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reference stream, valid held high then toggling.
        stimQ = '{8'h3C, 8'h08, 8'h10, 8'h00, 8'h20, 8'h09, 8'h00, 8'h05};
        runLoad(2, 0, 0, 0, -1);
        stimQ = '{8'h3C, 8'h08, 8'h10, 8'h00, 8'h20, 8'h09, 8'h00, 8'h05};
        runLoad(2, 1, 0, 0, -1);

        // Empty image.
        randStim(0);
        runLoad(0, 0, 0, 0, -1);

        // Restart attempts while busy must be ignored.
        randStim(3);
        runLoad(3, 0, 1, 0, -1);

        // Checksum image 01..04 (sum 0x0A), good and bad trailer.
        stimQ = '{8'h01, 8'h02, 8'h03, 8'h04};
        runLoad(1, 0, 0, 0, -1);
        stimQ = '{8'h01, 8'h02, 8'h03, 8'h04};
        runLoad(1, 0, 0, 1, -1);

        // Reset after 5 bytes of a 3-word load, then reload from index 0.
        randStim(3);
        runLoad(3, 0, 0, 0, 5);
        rst = 1'b0;
        #1 checkResetState("rst_mid");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        randStim(2);
        runLoad(2, 2, 0, 0, -1);

        // Randomized loads.
        for (int t = 0; t < 12; t++) begin
            int n;
            n = $urandom_range(0, 6);
            randStim(n);
            runLoad(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1);
        end

        // Full-size image: index wraps only after the last write.
        randStim(1 << ADDR_W);
        runLoad(1 << ADDR_W, 0, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
